// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the cpu bus: mirrored work RAM, loadable program ROM,
// programmable read wait states. Optional sticky bus-fault capture under `BUS_FAULT_EN`.
module cpu_bus_responder #(
  parameter int READ_LATENCY  = 2,
  parameter int RAM_ADDR_BITS = 11,
  parameter int ROM_ADDR_BITS = 12
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [15:0]              address_i,
  input  logic                     address_valid_i,
  input  logic [7:0]               data_i,
  input  logic                     data_valid_i,
  output logic [7:0]               data_o,
  output logic                     data_valid_o,
  input  logic                     rom_load_en_i,
  input  logic [ROM_ADDR_BITS-1:0] rom_load_addr_i,
  input  logic [7:0]               rom_load_data_i
`ifdef BUS_FAULT_EN
  ,
  output logic                     fault_o,
  output logic [15:0]              fault_address_o
`endif
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ_HOLD, S_WRITE_HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      cap_addr;
  logic             cap_wr;
  logic [7:0]       open_bus;

  logic [7:0] ram [0:(2**RAM_ADDR_BITS)-1];
  logic [7:0] rom [0:(2**ROM_ADDR_BITS)-1];

  function automatic logic is_ram(input logic [15:0] a);
    return a[15:13] == 3'b000;
  endfunction

  function automatic logic is_rom(input logic [15:0] a);
    return a[15];
  endfunction

  logic capture, ram_we;
  logic [7:0] rom_rd, rd_data;

  assign capture = address_valid_i &&
                   (state == S_IDLE || address_i != cap_addr || data_valid_i != cap_wr);
  // Gated by reset so a write pending when reset arrives never lands.
  assign ram_we  = capture && data_valid_i && is_ram(address_i) && !reset_i;

  // A same-cycle load to the index being sampled wins over the stored byte.
  assign rom_rd  = (rom_load_en_i && rom_load_addr_i == cap_addr[ROM_ADDR_BITS-1:0]) ?
                   rom_load_data_i : rom[cap_addr[ROM_ADDR_BITS-1:0]];
  assign rd_data = is_ram(cap_addr) ? ram[cap_addr[RAM_ADDR_BITS-1:0]] :
                   is_rom(cap_addr) ? rom_rd : open_bus;

  always_ff @(posedge clock_i) begin
    if (ram_we) ram[address_i[RAM_ADDR_BITS-1:0]] <= data_i;
  end

  always_ff @(posedge clock_i) begin
    if (rom_load_en_i) rom[rom_load_addr_i] <= rom_load_data_i;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      cap_addr     <= '0;
      cap_wr       <= 1'b0;
      open_bus     <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
    end else if (!address_valid_i) begin
      state        <= S_IDLE;
      data_valid_o <= 1'b0;
    end else if (capture) begin
      cap_addr     <= address_i;
      cap_wr       <= data_valid_i;
      data_valid_o <= 1'b0;
      if (data_valid_i) begin
        open_bus <= data_i;
        state    <= S_WRITE_HOLD;
      end else begin
        cnt   <= CNT_W'(READ_LATENCY - 1);
        state <= S_WAIT;
      end
    end else if (state == S_WAIT) begin
      if (cnt == '0) begin
        data_o       <= rd_data;
        open_bus     <= rd_data;
        data_valid_o <= 1'b1;
        state        <= S_READ_HOLD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

`ifdef BUS_FAULT_EN
  logic fault_hit;
  assign fault_hit = capture && ((data_valid_i && is_rom(address_i)) ||
                                 (!is_rom(address_i) && !is_ram(address_i)));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fault_o         <= 1'b0;
      fault_address_o <= '0;
    end else if (fault_hit && !fault_o) begin
      fault_o         <= 1'b1;
      fault_address_o <= address_i;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Bench for cpu_bus_responder: transaction-level reference model plus directed
// literal checks, followed by randomized bus traffic with interleaved ROM loads.
module tb_cpu_bus_responder;
  localparam int N = 2;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [15:0] address_i;
  logic        address_valid_i;
  logic [7:0]  data_i;
  logic        data_valid_i;
  logic [7:0]  data_o;
  logic        data_valid_o;
  logic        rom_load_en_i;
  logic [11:0] rom_load_addr_i;
  logic [7:0]  rom_load_data_i;
`ifdef BUS_FAULT_EN
  logic        fault_o;
  logic [15:0] fault_address_o;
`endif

  cpu_bus_responder #(.READ_LATENCY(N), .RAM_ADDR_BITS(11), .ROM_ADDR_BITS(12)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .address_i(address_i), .address_valid_i(address_valid_i),
    .data_i(data_i), .data_valid_i(data_valid_i),
    .data_o(data_o), .data_valid_o(data_valid_o),
    .rom_load_en_i(rom_load_en_i), .rom_load_addr_i(rom_load_addr_i),
    .rom_load_data_i(rom_load_data_i)
`ifdef BUS_FAULT_EN
    , .fault_o(fault_o), .fault_address_o(fault_address_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request is "open" once seen; a read completes N clocks later.
  logic [7:0]  ram_m [0:2047];
  logic [7:0]  rom_m [0:4095];
  logic [7:0]  m_do, m_ob, v;
  logic        m_dv, m_open, m_wr, m_pend, m_fault;
  logic [15:0] m_addr, m_faddr;
  int          m_age;

  function automatic int region(input logic [15:0] a);
    if (a < 16'h2000) return 0;
    if (a >= 16'h8000) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_dv = 0; m_do = 0; m_ob = 0; m_open = 0; m_pend = 0;
    m_fault = 0; m_faddr = 0; m_addr = 0; m_wr = 0; m_age = 0;
  endtask

  always @(posedge reset_i) model_reset();

  always @(posedge clock_i) begin
    if (rom_load_en_i) rom_m[rom_load_addr_i] = rom_load_data_i;
    if (reset_i) model_reset();
    else if (!address_valid_i) begin
      m_open = 0; m_dv = 0; m_pend = 0;
    end else if (!m_open || address_i != m_addr || data_valid_i != m_wr) begin
      m_open = 1; m_addr = address_i; m_wr = data_valid_i; m_dv = 0;
      if (!m_fault && ((data_valid_i && region(address_i) == 1) || region(address_i) == 2)) begin
        m_fault = 1; m_faddr = address_i;
      end
      if (data_valid_i) begin
        if (region(address_i) == 0) ram_m[address_i[10:0]] = data_i;
        m_ob = data_i; m_pend = 0;
      end else begin
        m_pend = 1; m_age = 0;
      end
    end else if (m_pend) begin
      m_age++;
      if (m_age == N) begin
        case (region(m_addr))
          0:       v = ram_m[m_addr[10:0]];
          1:       v = rom_m[m_addr[11:0]];
          default: v = m_ob;
        endcase
        m_do = v; m_ob = v; m_dv = 1; m_pend = 0;
      end
    end
  end

  always @(negedge clock_i) begin
    if (check_en) begin
      chk("model_dv", {15'd0, data_valid_o}, {15'd0, m_dv});
      chk("model_do", {8'd0, data_o}, {8'd0, m_do});
`ifdef BUS_FAULT_EN
      chk("model_fault", {15'd0, fault_o}, {15'd0, m_fault});
      chk("model_faddr", fault_address_o, m_faddr);
`endif
    end
  end

  task automatic set_bus(input logic [15:0] a, input logic av, input logic w, input logic [7:0] d);
    @(negedge clock_i);
    address_i = a; address_valid_i = av; data_valid_i = w; data_i = d; rom_load_en_i = 0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clock_i);
  endtask

  task automatic read_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
    set_bus(a, 1, 0, 8'h00);
    wait_n(2);
    chk({name, "_early"}, {15'd0, data_valid_o}, 16'd0);
    wait_n(1);
    chk({name, "_dv"}, {15'd0, data_valid_o}, 16'd1);
    chk({name, "_do"}, {8'd0, data_o}, {8'd0, exp});
  endtask

  initial begin
    reset_i = 1; address_i = 0; address_valid_i = 0; data_i = 0; data_valid_i = 0;
    rom_load_en_i = 0; rom_load_addr_i = 0; rom_load_data_i = 0;
    wait_n(3);
    chk("reset_do", {8'd0, data_o}, 16'd0);
    chk("reset_dv", {15'd0, data_valid_o}, 16'd0);
    reset_i = 0;
    check_en = 1;

    for (int i = 0; i < 4096; i++) begin
      @(negedge clock_i);
      rom_load_en_i = 1; rom_load_addr_i = 12'(i);
      case (i)
        12'hFFC: rom_load_data_i = 8'h00;
        12'hFFD: rom_load_data_i = 8'h80;
        12'h000: rom_load_data_i = 8'h3C;
        12'h001: rom_load_data_i = 8'hC3;
        default: rom_load_data_i = 8'($urandom);
      endcase
    end
    for (int i = 0; i < 2048; i++) set_bus(16'(i), 1, 1, 8'($urandom));
    set_bus(0, 0, 0, 0);

    read_chk("vec_lo", 16'hFFFC, 8'h00);
    read_chk("vec_hi", 16'hFFFD, 8'h80);

    set_bus(16'h9000, 1, 1, 8'h77);
    wait_n(2);
    read_chk("rom_wr_ignored", 16'h9000, 8'h3C);
`ifdef BUS_FAULT_EN
    chk("fault_set", {15'd0, fault_o}, 16'd1);
    chk("fault_addr", fault_address_o, 16'h9000);
`endif

    // Data changes while the strobe is held; only the first byte may commit.
    set_bus(16'h0012, 1, 1, 8'h5A);
    wait_n(1);
    data_i = 8'hA5;
    wait_n(11);
    read_chk("ram_mirror", 16'h0812, 8'h5A);
    read_chk("open_bus", 16'h4000, 8'h5A);

    set_bus(16'h8000, 1, 0, 0);
    wait_n(1);
    address_i = 16'h8001;
    wait_n(1);
    chk("restart_a", {15'd0, data_valid_o}, 16'd0);
    wait_n(1);
    chk("restart_b", {15'd0, data_valid_o}, 16'd0);
    wait_n(1);
    chk("restart_dv", {15'd0, data_valid_o}, 16'd1);
    chk("restart_do", {8'd0, data_o}, 16'h00C3);

    set_bus(16'hFFFD, 1, 0, 0);
    wait_n(1);
    #2 reset_i = 1;
    #1;
    chk("async_rst_dv", {15'd0, data_valid_o}, 16'd0);
    chk("async_rst_do", {8'd0, data_o}, 16'd0);
    address_valid_i = 0;
    wait_n(1);
    reset_i = 0;
`ifdef BUS_FAULT_EN
    chk("fault_clr", {15'd0, fault_o}, 16'd0);
`endif
    read_chk("post_rst", 16'hFFFD, 8'h80);

    for (int t = 0; t < 600; t++) begin
      int r, hold;
      logic [15:0] a;
      r = $urandom_range(0, 9);
      if (r < 4)      a = 16'($urandom_range(0, 16'h1FFF));
      else if (r < 8) a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
      else            a = 16'($urandom_range(16'h2000, 16'h7FFF));
      set_bus(a, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, 8'($urandom));
      hold = $urandom_range(1, 5);
      for (int h = 1; h < hold; h++) begin
        @(negedge clock_i);
        data_i = 8'($urandom);
        rom_load_en_i = ($urandom_range(0, 3) == 0);
        rom_load_addr_i = $urandom_range(0, 1) ? a[11:0] : 12'($urandom);
        rom_load_data_i = 8'($urandom);
      end
    end
    set_bus(0, 0, 0, 0);
    wait_n(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
